// File: rtl/uart_resp_tx_if.sv
// Response handshake between the command processor and the response transmitter.
interface uart_resp_tx_if;
    logic [15:0] resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;

    modport master (output resp, output send_resp, input tx_busy, input resp_sent);
    modport slave  (input resp, input send_resp, output tx_busy, output resp_sent);
endinterface

// File: rtl/uart_resp_tx.sv
// Serializes a 16-bit response as two back-to-back 8N1 frames, low byte first.
//
// state     | meaning
// IDLE      | line idle high, waiting for send_resp
// LOW_BYTE  | shifting start, resp[7:0], stop
// HIGH_BYTE | shifting start, resp[15:8], stop
module uart_resp_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_resp_tx_if.slave   bus,
    output logic            TX
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOW_BYTE  = 2'd1,
        HIGH_BYTE = 2'd2
    } state_t;

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  LAST_BIT  = 4'd9;

    state_t      state, state_nx;
    logic [15:0] hold, hold_nx;
    logic [9:0]  shreg, shreg_nx;
    logic [11:0] baud_cnt, baud_cnt_nx;
    logic [3:0]  bit_cnt, bit_cnt_nx;
    logic        busy, busy_nx;
    logic        sent, sent_nx;
    logic        baud_wrap;

    assign baud_wrap     = (baud_cnt == BAUD_LAST);
    assign TX            = shreg[0];
    assign bus.tx_busy   = busy;
    assign bus.resp_sent = sent;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold     <= '0;
            shreg    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            sent     <= 1'b0;
        end else begin
            state    <= state_nx;
            hold     <= hold_nx;
            shreg    <= shreg_nx;
            baud_cnt <= baud_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            busy     <= busy_nx;
            sent     <= sent_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        hold_nx     = hold;
        shreg_nx    = shreg;
        baud_cnt_nx = baud_cnt;
        bit_cnt_nx  = bit_cnt;
        busy_nx     = busy;
        sent_nx     = sent;

        case (state)
            IDLE: begin
                if (bus.send_resp) begin
                    hold_nx     = bus.resp;
                    shreg_nx    = {1'b1, bus.resp[7:0], 1'b0};
                    baud_cnt_nx = '0;
                    bit_cnt_nx  = '0;
                    busy_nx     = 1'b1;
                    sent_nx     = 1'b0;
                    state_nx    = LOW_BYTE;
                end
            end

            LOW_BYTE, HIGH_BYTE: begin
                if (!baud_wrap) begin
                    baud_cnt_nx = baud_cnt + 12'd1;
                end else begin
                    baud_cnt_nx = '0;
                    if (bit_cnt != LAST_BIT) begin
                        shreg_nx   = {1'b1, shreg[9:1]};
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else begin
                        bit_cnt_nx = '0;
                        // High-byte start bit begins on the same edge the low stop bit ends.
                        if (state == LOW_BYTE) begin
                            shreg_nx = {1'b1, hold[15:8], 1'b0};
                            state_nx = HIGH_BYTE;
                        end else begin
                            shreg_nx = '1;
                            busy_nx  = 1'b0;
                            sent_nx  = 1'b1;
                            state_nx = IDLE;
                        end
                    end
                end
            end

            default: begin
                shreg_nx = '1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_resp_tx.sv
// Randomized bench for uart_resp_tx against a timing-arithmetic reference model.
module tb_uart_resp_tx;

    localparam int BD    = 16;
    localparam int BYTE  = 10 * BD;
    localparam int XFER  = 20 * BD;
    localparam int HMAX  = 16384;

    logic clk = 1'b0;
    logic rst_n;
    logic TX;

    uart_resp_tx_if u_if ();

    uart_resp_tx #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave),
        .TX    (TX)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    logic        m_busy = 1'b0;
    logic        m_sent = 1'b0;
    int          m_start = 0;
    logic [15:0] m_word = '0;

    logic tx_hist   [HMAX];
    logic busy_hist [HMAX];
    logic sent_hist [HMAX];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic model_tx();
        int off, byte_i, bit_i;
        if (!m_busy) return 1'b1;
        off    = cyc - m_start;
        byte_i = off / BYTE;
        bit_i  = (off % BYTE) / BD;
        if (bit_i == 0) return 1'b0;
        if (bit_i == 9) return 1'b1;
        return m_word[byte_i * 8 + bit_i - 1];
    endfunction

    task automatic step(input logic s, input logic [15:0] r, input logic rn);
        u_if.send_resp = s;
        u_if.resp      = r;
        rst_n          = rn;
        @(posedge clk);
        cyc++;
        #1;
        if (!rn) begin
            m_busy = 1'b0;
            m_sent = 1'b0;
        end else if (m_busy) begin
            if (cyc - m_start == XFER) begin
                m_busy = 1'b0;
                m_sent = 1'b1;
            end
        end else if (s) begin
            m_busy  = 1'b1;
            m_start = cyc;
            m_word  = r;
            m_sent  = 1'b0;
        end
        check("tx", 32'(TX), 32'(model_tx()));
        check("tx_busy", 32'(u_if.tx_busy), 32'(m_busy));
        check("resp_sent", 32'(u_if.resp_sent), 32'(m_sent));
        if (cyc < HMAX) begin
            tx_hist[cyc]   = TX;
            busy_hist[cyc] = u_if.tx_busy;
            sent_hist[cyc] = u_if.resp_sent;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 1'b1);
    endtask

    initial begin
        int a;
        int rises;
        int rise_at[$];
        logic [19:0] basic_exp;

        u_if.send_resp = 1'b0;
        u_if.resp      = '0;
        rst_n          = 1'b0;

        // reset sanity
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b0);
            check("rst_tx", 32'(TX), 32'd1);
            check("rst_busy", 32'(u_if.tx_busy), 32'd0);
            check("rst_sent", 32'(u_if.resp_sent), 32'd0);
        end
        idle(5);

        // basic transfer
        step(1'b1, 16'hA53C, 1'b1);
        a = cyc;
        idle(XFER + 10);
        basic_exp = 20'b1101001010_1001111000;
        for (int k = 0; k < 20; k++)
            check("basic_bit", 32'(tx_hist[a + k * BD + BD / 2]), 32'(basic_exp[k]));
        check("basic_busy_before", 32'(busy_hist[a + XFER - 1]), 32'd1);
        check("basic_busy_done", 32'(busy_hist[a + XFER]), 32'd0);
        check("basic_sent_done", 32'(sent_hist[a + XFER]), 32'd1);
        check("basic_sent_before", 32'(sent_hist[a + XFER - 1]), 32'd0);

        // busy ignore
        step(1'b1, 16'h1234, 1'b1);
        a = cyc;
        for (int i = 0; i < 49; i++) step(1'b0, 16'h1234, 1'b1);
        step(1'b1, 16'hFFFF, 1'b1);
        idle(400);
        rises = 0;
        for (int c = a; c <= cyc; c++)
            if (sent_hist[c] && !sent_hist[c - 1]) rises++;
        check("busy_ignore_sent_rises", 32'(rises), 32'd1);
        check("busy_ignore_hi_bit", 32'(tx_hist[a + BYTE + BD + BD / 2]), 32'd0);

        // back-to-back with send_resp held
        idle(3);
        a = cyc + 1;
        for (int i = 0; i < 3 * (XFER + 1); i++) step(1'b1, 16'h00FF, 1'b1);
        idle(5);
        for (int c = a; c <= cyc; c++)
            if (busy_hist[c] && !busy_hist[c - 1]) rise_at.push_back(c);
        check("b2b_count", 32'(rise_at.size()), 32'd3);
        if (rise_at.size() == 3) begin
            check("b2b_period1", 32'(rise_at[1] - rise_at[0]), 32'(XFER + 1));
            check("b2b_period2", 32'(rise_at[2] - rise_at[1]), 32'(XFER + 1));
        end
        check("b2b_gap_high", 32'(tx_hist[a + XFER]), 32'd1);
        check("b2b_next_start", 32'(tx_hist[a + XFER + 1]), 32'd0);
        check("b2b_sent_pulse", 32'(sent_hist[a + XFER]), 32'd1);
        check("b2b_sent_clear", 32'(sent_hist[a + XFER + 1]), 32'd0);

        // reset mid-frame, inside the high byte
        step(1'b1, 16'h5555, 1'b1);
        a = cyc;
        for (int i = 0; i < 169; i++) step(1'b0, 16'h5555, 1'b1);
        step(1'b0, 16'h5555, 1'b0);
        check("midrst_tx", 32'(TX), 32'd1);
        check("midrst_busy", 32'(u_if.tx_busy), 32'd0);
        idle(XFER);
        check("midrst_no_sent", 32'(u_if.resp_sent), 32'd0);
        step(1'b1, 16'($urandom), 1'b1);
        idle(XFER + 5);

        // sticky flag
        idle(1000);
        check("sticky_hold", 32'(u_if.resp_sent), 32'd1);
        step(1'b1, 16'($urandom), 1'b1);
        check("sticky_clear", 32'(u_if.resp_sent), 32'd0);
        idle(XFER + 5);

        // random traffic: sparse requests, resp churn, occasional reset
        for (int t = 0; t < 10; t++) begin
            idle($urandom_range(0, 20));
            for (int i = 0; i < XFER + 40; i++)
                step(($urandom_range(0, 25) == 0), 16'($urandom), ($urandom_range(0, 1500) != 0));
        end
        idle(XFER + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
